// File: rtl/pipelined_adder.sv
// Streaming add/sub unit whose carry chain is cut into STAGES segments, one per pipeline stage.
// Optional saturation on signed overflow is enabled by defining PIPELINED_ADDER_SAT_EN.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             Zero,
  output logic             Neg
);

  localparam int SEG = WIDTH / STAGES;

  // Registers between stages; index k holds the result of stage k (last index unused).
  logic [WIDTH-1:0] a_r     [STAGES];
  logic [WIDTH-1:0] bop_r   [STAGES];
  logic [WIDTH-1:0] psum_r  [STAGES];
  logic             carry_r [STAGES];
  logic             vld_r   [STAGES];

  logic [WIDTH-1:0] nx_a_s     [STAGES];
  logic [WIDTH-1:0] nx_bop_s   [STAGES];
  logic [WIDTH-1:0] nx_psum_s  [STAGES];
  logic             nx_carry_s [STAGES];
  logic             nx_vld_s   [STAGES];

  logic [WIDTH-1:0] sum_r;
  logic             out_valid_r;
  logic             cout_r;
  logic             ovf_r;
  logic             zero_r;
  logic             neg_r;

  logic             adv_s;
  logic [WIDTH-1:0] fin_raw_s;
  logic [WIDTH-1:0] fin_s;
  logic             a_msb_s;
  logic             b_msb_s;
  logic             ovf_s;

  assign adv_s   = !out_valid_r || OutReady;
  assign InReady = adv_s;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] in_a_s;
    logic [WIDTH-1:0] in_bop_s;
    logic [WIDTH-1:0] in_psum_s;
    logic             in_carry_s;
    logic             in_vld_s;
    logic [SEG:0]     seg_s;
    logic [WIDTH-1:0] psum_s;

    if (k == 0) begin : g_first
      // Subtract is A + ~B + 1: the +1 rides in as the first carry.
      assign in_a_s     = A;
      assign in_bop_s   = Sub ? ~B : B;
      assign in_psum_s  = '0;
      assign in_carry_s = Sub;
      assign in_vld_s   = InValid;
    end else begin : g_next
      assign in_a_s     = a_r[k-1];
      assign in_bop_s   = bop_r[k-1];
      assign in_psum_s  = psum_r[k-1];
      assign in_carry_s = carry_r[k-1];
      assign in_vld_s   = vld_r[k-1];
    end

    assign seg_s = {1'b0, in_a_s[k*SEG +: SEG]} + {1'b0, in_bop_s[k*SEG +: SEG]}
                 + {{SEG{1'b0}}, in_carry_s};

    // Insert this stage's segment into the partially completed sum.
    always_comb begin
      psum_s = in_psum_s;
      psum_s[k*SEG +: SEG] = seg_s[SEG-1:0];
    end

    assign nx_a_s[k]     = in_a_s;
    assign nx_bop_s[k]   = in_bop_s;
    assign nx_psum_s[k]  = psum_s;
    assign nx_carry_s[k] = seg_s[SEG];
    assign nx_vld_s[k]   = in_vld_s;
  end

  // Final-stage overflow detection and optional clamping.
  always_comb begin
    fin_raw_s = nx_psum_s[STAGES-1];
    a_msb_s   = nx_a_s[STAGES-1][WIDTH-1];
    b_msb_s   = nx_bop_s[STAGES-1][WIDTH-1];
    ovf_s     = (a_msb_s == b_msb_s) && (fin_raw_s[WIDTH-1] != a_msb_s);
    fin_s     = fin_raw_s;
`ifdef PIPELINED_ADDER_SAT_EN
    if (ovf_s) begin
      if (a_msb_s) begin
        fin_s = {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
        fin_s = {1'b0, {(WIDTH-1){1'b1}}};
      end
    end else begin
      fin_s = fin_raw_s;
    end
`else
    fin_s = fin_raw_s;
`endif
  end

  // Pipeline advance under the global enable; reset discards in-flight work.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES - 1; k++) begin
        vld_r[k]   <= 1'b0;
        a_r[k]     <= '0;
        bop_r[k]   <= '0;
        psum_r[k]  <= '0;
        carry_r[k] <= 1'b0;
      end
      out_valid_r <= 1'b0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      zero_r      <= 1'b0;
      neg_r       <= 1'b0;
    end else if (adv_s) begin
      for (int k = 0; k < STAGES - 1; k++) begin
        vld_r[k]   <= nx_vld_s[k];
        a_r[k]     <= nx_a_s[k];
        bop_r[k]   <= nx_bop_s[k];
        psum_r[k]  <= nx_psum_s[k];
        carry_r[k] <= nx_carry_s[k];
      end
      out_valid_r <= nx_vld_s[STAGES-1];
      sum_r       <= fin_s;
      cout_r      <= nx_carry_s[STAGES-1];
      ovf_r       <= ovf_s;
      zero_r      <= (fin_s == '0);
      neg_r       <= fin_s[WIDTH-1];
    end
  end

  assign OutValid = out_valid_r;
  assign Sum      = sum_r;
  assign Cout     = cout_r;
  assign Ovf      = ovf_r;
  assign Zero     = zero_r;
  assign Neg      = neg_r;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed self-checking bench for pipelined_adder (WIDTH=32, STAGES=4).
// Honours PIPELINED_ADDER_SAT_EN when selecting overflow expectations.
module tb_pipelined_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;
  logic        neg;

  int total;
  int bad;

  pipelined_adder #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .InValid(in_valid), .InReady(in_ready),
    .A(a), .B(b), .Sub(sub),
    .OutValid(out_valid), .OutReady(out_ready),
    .Sum(sum), .Cout(cout), .Ovf(ovf), .Zero(zero), .Neg(neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One isolated operation: accept, then confirm result appears exactly 4 cycles later.
  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic sv, input logic [31:0] es, input logic ec,
                        input logic eo, input logic ez, input logic en);
    a = av; b = bv; sub = sv; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk({tag, "_early"}, {31'd0, out_valid}, 32'd0);
    tick();
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
    chk({tag, "_zero"}, {31'd0, zero}, {31'd0, ez});
    chk({tag, "_neg"}, {31'd0, neg}, {31'd0, en});
    tick();
  endtask

  initial begin
    int sent;
    int rcv;
    int stall_left;
    bit stalled_once;
    bit accept;

    total = 0; bad = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = 32'd0; b = 32'd0; sub = 1'b0;
    tick();
    tick();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", sum, 32'd0);
    chk("rst_flags", {28'd0, cout, ovf, zero, neg}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_inready", {31'd0, in_ready}, 32'd1);

    // Back-to-back pair: 1+2 then 4+10.
    a = 32'd1; b = 32'd2; sub = 1'b0; in_valid = 1'b1;
    tick();
    a = 32'd4; b = 32'd10;
    tick();
    in_valid = 1'b0;
    tick();
    chk("pair_early", {31'd0, out_valid}, 32'd0);
    tick();
    chk("pair0_valid", {31'd0, out_valid}, 32'd1);
    chk("pair0_sum", sum, 32'd3);
    chk("pair0_flags", {28'd0, cout, ovf, zero, neg}, 32'd0);
    tick();
    chk("pair1_valid", {31'd0, out_valid}, 32'd1);
    chk("pair1_sum", sum, 32'd14);
    tick();
    chk("pair_drained", {31'd0, out_valid}, 32'd0);

    run_op("segcarry", 32'h0000FFFF, 32'd1, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("wrap", 32'hFFFFFFFF, 32'd1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0);
`ifdef PIPELINED_ADDER_SAT_EN
    run_op("posovf", 32'h7FFFFFFF, 32'd1, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op("negovf", 32'h80000000, 32'd1, 1'b1, 32'h80000000, 1'b1, 1'b1, 1'b0, 1'b1);
`else
    run_op("posovf", 32'h7FFFFFFF, 32'd1, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1);
    run_op("negovf", 32'h80000000, 32'd1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0);
`endif
    run_op("sub5m7", 32'd5, 32'd7, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op("sub7m5", 32'd7, 32'd5, 1'b1, 32'h00000002, 1'b1, 1'b0, 1'b0, 1'b0);

    // Stream i + 100*i, stalling the consumer for 3 cycles once the first result appears.
    sent = 0; rcv = 0; stall_left = 0; stalled_once = 1'b0;
    for (int cyc = 0; cyc < 60 && rcv < 8; cyc++) begin
      if (out_valid && !stalled_once) begin
        stalled_once = 1'b1;
        stall_left = 3;
      end
      out_ready = (stall_left == 0);
      in_valid = (sent < 8);
      a = sent;
      b = 100 * sent;
      sub = 1'b0;
      #1;
      if (stall_left > 0) begin
        chk("bp_inready_stall", {31'd0, in_ready}, 32'd0);
        chk("bp_hold_sum", sum, 32'(101 * rcv));
      end
      accept = in_valid && in_ready;
      if (out_valid && out_ready) begin
        chk("bp_sum", sum, 32'(101 * rcv));
        rcv++;
      end
      if (accept) sent++;
      if (stall_left > 0) stall_left--;
      @(posedge clk);
      #1;
    end
    chk("bp_count", rcv, 32'd8);
    chk("bp_stalled", {31'd0, stalled_once}, 32'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();

    // Mid-stream reset with three operations in flight.
    for (int i = 1; i <= 3; i++) begin
      a = 32'(11 * i); b = 32'd0; sub = 1'b0; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_sum", sum, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mrst_no_stale", {31'd0, out_valid}, 32'd0);
    end
    run_op("post_rst", 32'd9, 32'd1, 1'b0, 32'd10, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
